// File: rtl/burst_transmitter_pkg.sv
// Shared types, end-cause codes and parity helper for the burst transmitter.
package burst_transmitter_pkg;

  // Transmitter control states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SEND   = 3'd3,
    ST_ACKLOW = 3'd4,
    ST_DONE   = 3'd5
  } tx_state_t;

  // Reason the last run ended.
  localparam logic [1:0] EC_LEN   = 2'b00;
  localparam logic [1:0] EC_SENT  = 2'b01;
  localparam logic [1:0] EC_LAST  = 2'b10;
  localparam logic [1:0] EC_ABORT = 2'b11;

  // Widest word the parity helper accepts; narrower words are zero-extended,
  // which leaves both XOR- and XNOR-reduction unchanged.
  localparam int PAR_MAX_W = 64;

  // Even mode drives XNOR-reduce(word), odd mode drives XOR-reduce(word).
  function automatic logic tx_parity(input logic [PAR_MAX_W-1:0] word, input logic odd);
    logic red_s;
    red_s = ^word;
    if (odd) begin
      return red_s;
    end else begin
      return ~red_s;
    end
  endfunction

endpackage

// File: rtl/burst_transmitter.sv
// Streams a run of words from a synchronous source RAM onto a four-phase
// req/ack link with a per-word parity bit. A run is armed by start and ends
// on sentinel, programmed length, last address or abort.
module burst_transmitter
  import burst_transmitter_pkg::*;
#(
  parameter int              ADDR_W   = 12,
  parameter int              WIDTH    = 16,
  parameter logic [WIDTH-1:0] SENTINEL = {WIDTH{1'b1}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_start,
  input  logic [ADDR_W:0]   src_len,
  input  logic              sentinel_en,
  input  logic              odd_parity,
  input  logic              abort,
  output logic [ADDR_W-1:0] src_addr,
  output logic              src_rd,
  input  logic [WIDTH-1:0]  src_dout,
  output logic              req,
  input  logic              ack,
  input  logic              full,
  output logic [WIDTH-2:0]  bus_data,
  output logic              bus_msb,
  output logic              parity,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words_sent,
  output logic [1:0]        end_cause
);

  tx_state_t         state_r;
  tx_state_t         state_s;
  logic [1:0]        cause_s;
  logic              accept_s;
  logic              start_ok_s;
  logic              hit_sent_s;
  logic              hit_len_s;
  logic              hit_last_s;
  logic [ADDR_W:0]   cnt_inc_s;

  logic [ADDR_W:0]   len_r;
  logic              sent_en_r;
  logic              odd_r;
  logic [ADDR_W-1:0] src_addr_r;
  logic              src_rd_r;
  logic              req_r;
  logic [WIDTH-1:0]  word_r;
  logic              parity_r;
  logic              busy_r;
  logic              done_r;
  logic [ADDR_W:0]   words_sent_r;
  logic [1:0]        end_cause_r;

  assign start_ok_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign cnt_inc_s  = words_sent_r + {{ADDR_W{1'b0}}, 1'b1};
  assign hit_sent_s = sent_en_r && (word_r == SENTINEL);
  assign hit_len_s  = (len_r != {(ADDR_W+1){1'b0}}) && (cnt_inc_s == len_r);
  assign hit_last_s = (src_addr_r == {ADDR_W{1'b1}});

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state, word acceptance and end-cause selection.
  always_comb begin
    state_s  = state_r;
    cause_s  = EC_LEN;
    accept_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_s = ST_FETCH;
        end else begin
          state_s = state_r;
        end
      end
      ST_FETCH: begin
        if (abort) begin
          state_s = ST_DONE;
          cause_s = EC_ABORT;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (abort) begin
          state_s = ST_DONE;
          cause_s = EC_ABORT;
        end else begin
          state_s = ST_SEND;
        end
      end
      ST_SEND: begin
        accept_s = req_r && ack;
        if (abort) begin
          state_s = ST_DONE;
          cause_s = EC_ABORT;
        end else if (accept_s) begin
          if (hit_sent_s) begin
            state_s = ST_DONE;
            cause_s = EC_SENT;
          end else if (hit_len_s) begin
            state_s = ST_DONE;
            cause_s = EC_LEN;
          end else if (hit_last_s) begin
            state_s = ST_DONE;
            cause_s = EC_LAST;
          end else begin
            state_s = ST_ACKLOW;
          end
        end else begin
          state_s = ST_SEND;
        end
      end
      ST_ACKLOW: begin
        if (abort) begin
          state_s = ST_DONE;
          cause_s = EC_ABORT;
        end else if (!ack) begin
          state_s = ST_FETCH;
        end else begin
          state_s = ST_ACKLOW;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Status outputs registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_rd_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      req_r    <= 1'b0;
    end else begin
      src_rd_r <= (state_s == ST_FETCH);
      busy_r   <= (state_s == ST_FETCH) || (state_s == ST_WAIT) ||
                  (state_s == ST_SEND)  || (state_s == ST_ACKLOW);
      done_r   <= (state_s == ST_DONE);
      // Offer the word only while the receiver is neither full nor acking;
      // a held word is simply re-offered once full clears.
      req_r    <= (state_s == ST_SEND) && !full && !ack;
    end
  end

  // Run configuration, address, word capture, counter and end cause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_r        <= {(ADDR_W+1){1'b0}};
      sent_en_r    <= 1'b0;
      odd_r        <= 1'b0;
      src_addr_r   <= {ADDR_W{1'b0}};
      word_r       <= {WIDTH{1'b0}};
      parity_r     <= 1'b0;
      words_sent_r <= {(ADDR_W+1){1'b0}};
      end_cause_r  <= EC_LEN;
    end else begin
      if (start_ok_s) begin
        len_r        <= src_len;
        sent_en_r    <= sentinel_en;
        odd_r        <= odd_parity;
        src_addr_r   <= src_start;
        words_sent_r <= {(ADDR_W+1){1'b0}};
        end_cause_r  <= EC_LEN;
      end else begin
        if ((state_r == ST_WAIT) && (state_s == ST_SEND)) begin
          word_r   <= src_dout;
          parity_r <= tx_parity(PAR_MAX_W'(src_dout), odd_r);
        end else begin
          word_r   <= word_r;
          parity_r <= parity_r;
        end
        if (accept_s) begin
          words_sent_r <= cnt_inc_s;
        end else begin
          words_sent_r <= words_sent_r;
        end
        if (accept_s && (state_s == ST_ACKLOW)) begin
          src_addr_r <= src_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
          src_addr_r <= src_addr_r;
        end
        if ((state_s == ST_DONE) && (state_r != ST_DONE)) begin
          end_cause_r <= cause_s;
        end else begin
          end_cause_r <= end_cause_r;
        end
      end
    end
  end

  assign src_addr   = src_addr_r;
  assign src_rd     = src_rd_r;
  assign req        = req_r;
  assign bus_data   = word_r[WIDTH-2:0];
  assign bus_msb    = word_r[WIDTH-1];
  assign parity     = parity_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign words_sent = words_sent_r;
  assign end_cause  = end_cause_r;

endmodule

// File: tb/tb_burst_transmitter.sv
// Directed bench for burst_transmitter with a RAM model and a req/ack receiver.
module tb_burst_transmitter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] src_start = 12'h000;
  logic [12:0] src_len = 13'h0000;
  logic        sentinel_en = 1'b0;
  logic        odd_parity = 1'b0;
  logic        abort = 1'b0;
  logic [11:0] src_addr;
  logic        src_rd;
  logic [15:0] src_dout = 16'h0000;
  logic        req;
  logic        ack = 1'b0;
  logic        full = 1'b0;
  logic [14:0] bus_data;
  logic        bus_msb;
  logic        parity;
  logic        busy;
  logic        done;
  logic [12:0] words_sent;
  logic [1:0]  end_cause;

  int err = 0;
  int chk = 0;

  logic [15:0] mem [0:4095];
  logic [15:0] rx_word_q [$];
  logic        rx_par_q [$];
  int          rd_cnt = 0;
  int          ack_dly = 2;
  int          ack_hold = 1;
  int          wait_cnt = 0;
  int          hold_cnt = 0;

  burst_transmitter dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_start(src_start),
    .src_len(src_len), .sentinel_en(sentinel_en), .odd_parity(odd_parity),
    .abort(abort), .src_addr(src_addr), .src_rd(src_rd), .src_dout(src_dout),
    .req(req), .ack(ack), .full(full), .bus_data(bus_data), .bus_msb(bus_msb),
    .parity(parity), .busy(busy), .done(done), .words_sent(words_sent),
    .end_cause(end_cause)
  );

  always #5 clk = ~clk;

  // Synchronous source RAM: data valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (src_rd) src_dout <= mem[src_addr];
  end

  // Receiver: raise ack ack_dly cycles after req, drop it ack_hold cycles after req falls.
  always @(negedge clk) begin
    if (!rst_n) begin
      ack = 1'b0; wait_cnt = 0; hold_cnt = 0;
    end else if (req && !ack) begin
      wait_cnt = wait_cnt + 1;
      if (wait_cnt >= ack_dly) begin
        ack = 1'b1; wait_cnt = 0;
        rx_word_q.push_back({bus_msb, bus_data});
        rx_par_q.push_back(parity);
      end
    end else if (ack && !req) begin
      hold_cnt = hold_cnt + 1;
      if (hold_cnt >= ack_hold) begin
        ack = 1'b0; hold_cnt = 0;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Count read strobe cycles.
  always @(negedge clk) begin
    if (src_rd) rd_cnt = rd_cnt + 1;
  end

  task automatic kick(input logic [11:0] a, input logic [12:0] l, input logic s, input logic o);
    @(negedge clk);
    src_start = a; src_len = l; sentinel_en = s; odd_parity = o; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && !done; i++) @(negedge clk);
    chk++;
    if (done !== 1'b1) begin err++; $display("FAIL wait_done: done=%0b after timeout, expected 1", done); end
  endtask

  task automatic test_reset();
    chk++; if (req !== 1'b0)         begin err++; $display("FAIL rst_req: got %0b expected 0", req); end
    chk++; if (busy !== 1'b0)        begin err++; $display("FAIL rst_busy: got %0b expected 0", busy); end
    chk++; if (done !== 1'b0)        begin err++; $display("FAIL rst_done: got %0b expected 0", done); end
    chk++; if (src_rd !== 1'b0)      begin err++; $display("FAIL rst_src_rd: got %0b expected 0", src_rd); end
    chk++; if (src_addr !== 12'h000) begin err++; $display("FAIL rst_addr: got %h expected 000", src_addr); end
    chk++; if (words_sent !== 13'd0) begin err++; $display("FAIL rst_words: got %0d expected 0", words_sent); end
    chk++; if ({bus_msb, bus_data, parity, end_cause} !== 19'd0) begin
      err++; $display("FAIL rst_bus: got %h expected 0", {bus_msb, bus_data, parity, end_cause});
    end
  endtask

  task automatic test_length();
    int c;
    mem[12'h010] = 16'h0001; mem[12'h011] = 16'h0003; mem[12'h012] = 16'h8000; mem[12'h013] = 16'h5555;
    rx_word_q.delete(); rx_par_q.delete(); rd_cnt = 0; ack_dly = 2; ack_hold = 1;
    kick(12'h010, 13'd3, 1'b0, 1'b0);
    chk++; if ({src_rd, busy, req} !== 3'b110) begin err++; $display("FAIL len_e0: rd/busy/req=%b expected 110", {src_rd, busy, req}); end
    @(negedge clk);
    chk++; if ({src_rd, req} !== 2'b00) begin err++; $display("FAIL len_e1: rd/req=%b expected 00", {src_rd, req}); end
    @(negedge clk);
    chk++; if (req !== 1'b1) begin err++; $display("FAIL len_e2_req: got %0b expected 1", req); end
    c = 2;
    while (!done && c < 100) begin @(negedge clk); c++; end
    chk++; if (c != 14) begin err++; $display("FAIL len_latency: done at cycle %0d expected 14", c); end
    chk++; if (rx_word_q.size() != 3) begin err++; $display("FAIL len_count: got %0d words expected 3", rx_word_q.size()); end
    else begin
      chk++; if ({rx_word_q[0], rx_word_q[1], rx_word_q[2]} !== 48'h0001_0003_8000) begin
        err++; $display("FAIL len_words: got %h %h %h expected 0001 0003 8000", rx_word_q[0], rx_word_q[1], rx_word_q[2]);
      end
      chk++; if ({rx_par_q[0], rx_par_q[1], rx_par_q[2]} !== 3'b010) begin
        err++; $display("FAIL len_parity: got %b expected 010", {rx_par_q[0], rx_par_q[1], rx_par_q[2]});
      end
    end
    chk++; if (words_sent !== 13'd3) begin err++; $display("FAIL len_words_sent: got %0d expected 3", words_sent); end
    chk++; if ({done, busy, end_cause} !== 4'b1000) begin err++; $display("FAIL len_status: done/busy/cause=%b expected 1000", {done, busy, end_cause}); end
    chk++; if (rd_cnt != 3) begin err++; $display("FAIL len_reads: got %0d expected 3", rd_cnt); end
  endtask

  task automatic test_sentinel();
    mem[12'h100] = 16'h1234; mem[12'h101] = 16'hFFFF; mem[12'h102] = 16'h0055;
    rx_word_q.delete(); rx_par_q.delete(); rd_cnt = 0;
    kick(12'h100, 13'd0, 1'b1, 1'b1);
    wait_done();
    repeat (5) @(negedge clk);
    chk++; if (rx_word_q.size() != 2) begin err++; $display("FAIL sent_count: got %0d words expected 2", rx_word_q.size()); end
    else begin
      chk++; if (rx_word_q[1] !== 16'hFFFF) begin err++; $display("FAIL sent_word: got %h expected ffff", rx_word_q[1]); end
      chk++; if ({rx_par_q[0], rx_par_q[1]} !== 2'b10) begin err++; $display("FAIL sent_odd_parity: got %b expected 10", {rx_par_q[0], rx_par_q[1]}); end
    end
    chk++; if (end_cause !== 2'b01) begin err++; $display("FAIL sent_cause: got %b expected 01", end_cause); end
    chk++; if (words_sent !== 13'd2) begin err++; $display("FAIL sent_words_sent: got %0d expected 2", words_sent); end
    chk++; if (rd_cnt != 2) begin err++; $display("FAIL sent_reads: got %0d expected 2", rd_cnt); end
  endtask

  task automatic test_last_addr();
    mem[12'hFFE] = 16'h0A0A; mem[12'hFFF] = 16'h0B0B;
    rx_word_q.delete(); rx_par_q.delete(); rd_cnt = 0;
    kick(12'hFFE, 13'd0, 1'b1, 1'b0);
    wait_done();
    repeat (3) @(negedge clk);
    chk++; if (rx_word_q.size() != 2) begin err++; $display("FAIL last_count: got %0d words expected 2", rx_word_q.size()); end
    else begin
      chk++; if ({rx_word_q[0], rx_word_q[1]} !== 32'h0A0A_0B0B) begin err++; $display("FAIL last_words: got %h %h expected 0a0a 0b0b", rx_word_q[0], rx_word_q[1]); end
    end
    chk++; if (end_cause !== 2'b10) begin err++; $display("FAIL last_cause: got %b expected 10", end_cause); end
    chk++; if (src_addr !== 12'hFFF) begin err++; $display("FAIL last_addr: got %h expected fff", src_addr); end
    chk++; if (rd_cnt != 2) begin err++; $display("FAIL last_reads: got %0d expected 2", rd_cnt); end
  endtask

  task automatic test_full();
    logic held;
    mem[12'h200] = 16'h0011; mem[12'h201] = 16'h0022; mem[12'h202] = 16'h0033;
    rx_word_q.delete(); rx_par_q.delete(); ack_dly = 4;
    kick(12'h200, 13'd3, 1'b0, 1'b0);
    for (int i = 0; i < 100 && words_sent != 13'd1; i++) @(negedge clk);
    for (int i = 0; i < 100 && !req; i++) @(negedge clk);
    chk++; if ({req, bus_msb, bus_data} !== 17'h1_0022) begin err++; $display("FAIL full_pre: req/word=%h expected 10022", {req, bus_msb, bus_data}); end
    full = 1'b1;
    @(negedge clk);
    chk++; if (req !== 1'b0) begin err++; $display("FAIL full_drop: req=%0b expected 0", req); end
    held = 1'b1;
    repeat (4) begin @(negedge clk); if (req !== 1'b0 || {bus_msb, bus_data} !== 16'h0022) held = 1'b0; end
    chk++; if (held !== 1'b1) begin err++; $display("FAIL full_hold: req/word not held, got req=%0b word=%h", req, {bus_msb, bus_data}); end
    full = 1'b0;
    wait_done();
    chk++; if (rx_word_q.size() != 3) begin err++; $display("FAIL full_count: got %0d words expected 3", rx_word_q.size()); end
    else begin
      chk++; if ({rx_word_q[0], rx_word_q[1], rx_word_q[2]} !== 48'h0011_0022_0033) begin
        err++; $display("FAIL full_words: got %h %h %h expected 0011 0022 0033", rx_word_q[0], rx_word_q[1], rx_word_q[2]);
      end
    end
    chk++; if (words_sent !== 13'd3) begin err++; $display("FAIL full_words_sent: got %0d expected 3", words_sent); end
    ack_dly = 2;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_abort_restart();
    mem[12'h300] = 16'h0101; mem[12'h301] = 16'h0202; mem[12'h400] = 16'h0404;
    rx_word_q.delete(); rx_par_q.delete(); ack_hold = 3;
    kick(12'h300, 13'd0, 1'b0, 1'b0);
    for (int i = 0; i < 100 && words_sent != 13'd1; i++) @(negedge clk);
    chk++; if ({busy, req, ack} !== 3'b101) begin err++; $display("FAIL abort_acklow: busy/req/ack=%b expected 101", {busy, req, ack}); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk++; if ({done, busy, req, end_cause} !== 5'b10011) begin err++; $display("FAIL abort_done: done/busy/req/cause=%b expected 10011", {done, busy, req, end_cause}); end
    chk++; if (words_sent !== 13'd1) begin err++; $display("FAIL abort_words: got %0d expected 1", words_sent); end
    ack_hold = 1;
    repeat (4) @(negedge clk);
    rx_word_q.delete(); rx_par_q.delete();
    kick(12'h400, 13'd1, 1'b0, 1'b0);
    chk++; if ({done, busy, words_sent} !== 15'b01_0000000000000) begin err++; $display("FAIL restart_clear: done=%0b busy=%0b words=%0d expected 0 1 0", done, busy, words_sent); end
    wait_done();
    chk++; if (rx_word_q.size() != 1) begin err++; $display("FAIL restart_count: got %0d words expected 1", rx_word_q.size()); end
    else begin
      chk++; if (rx_word_q[0] !== 16'h0404) begin err++; $display("FAIL restart_word: got %h expected 0404", rx_word_q[0]); end
    end
    chk++; if ({end_cause, words_sent} !== 15'd1) begin err++; $display("FAIL restart_status: cause=%b words=%0d expected 00 1", end_cause, words_sent); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_send();
    mem[12'h500] = 16'h0505; mem[12'h600] = 16'h0606; mem[12'h601] = 16'h0607;
    ack_dly = 4;
    kick(12'h500, 13'd0, 1'b0, 1'b0);
    for (int i = 0; i < 100 && !req; i++) @(negedge clk);
    chk++; if (req !== 1'b1) begin err++; $display("FAIL rmid_req: got %0b expected 1", req); end
    #2 rst_n = 1'b0;
    #1;
    chk++; if ({req, busy, done, src_rd} !== 4'b0000) begin err++; $display("FAIL rmid_async: req/busy/done/rd=%b expected 0000", {req, busy, done, src_rd}); end
    @(negedge clk);
    rst_n = 1'b1; ack_dly = 2;
    repeat (2) @(negedge clk);
    chk++; if ({busy, src_addr, words_sent} !== 26'd0) begin err++; $display("FAIL rmid_idle: busy=%0b addr=%h words=%0d expected 0 000 0", busy, src_addr, words_sent); end
    rx_word_q.delete(); rx_par_q.delete();
    kick(12'h600, 13'd2, 1'b0, 1'b0);
    wait_done();
    chk++; if (rx_word_q.size() != 2) begin err++; $display("FAIL rmid_count: got %0d words expected 2", rx_word_q.size()); end
    else begin
      chk++; if ({rx_word_q[0], rx_word_q[1]} !== 32'h0606_0607) begin err++; $display("FAIL rmid_words: got %h %h expected 0606 0607", rx_word_q[0], rx_word_q[1]); end
    end
    chk++; if ({end_cause, words_sent} !== 15'd2) begin err++; $display("FAIL rmid_status: cause=%b words=%0d expected 00 2", end_cause, words_sent); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_length();
    test_sentinel();
    test_last_addr();
    test_full();
    test_abort_restart();
    test_reset_mid_send();
    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end

endmodule
